// File: rtl/sw_bank_reader_pkg.sv
// sw_bank_reader_pkg: shared types and constants for the switch-bank reader.
// Holds the debounce FSM state encoding and the default switch-bank width,
// which the LED/RGB blocks reuse so the whole board agrees on the bank size.
package sw_bank_reader_pkg;

    localparam int unsigned SW_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a bus of asynchronous levels.
// Ports: clk (rising edge), rst_n (sync active-low), d (async input bus),
//        q (bus delayed by two clk edges, safe to use in the clk domain).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/sw_bank_reader.sv
// sw_bank_reader: synchronises, debounces and reports the board switch bank.
// Ports: clk, rst_n (sync active-low); sw (raw switch levels);
//        sw_stable (current debounced level); out_data/out_changed/out_valid
//        with out_ready form a valid/ready report of each new stable value
//        and the bits that changed relative to the previously accepted value.
module sw_bank_reader
    import sw_bank_reader_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_changed,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sw),
        .q    (s2)
    );

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        data_d   = data_q;
        chg_d    = chg_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s2 != stable_q) begin
                    cand_d  = s2;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Falling back to the accepted level is a glitch, not a new value.
                if (s2 != cand_q && s2 == stable_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (s2 != cand_q) begin
                    cand_d = s2;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d = cand_q;
                    data_d   = cand_q;
                    chg_d    = cand_q ^ stable_q;
                    valid_d  = 1'b1;
                    state_d  = ST_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The input is deliberately ignored here; IDLE picks up any change later.
            ST_REPORT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            stable_q <= '0;
            data_q   <= '0;
            chg_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            data_q   <= data_d;
            chg_q    <= chg_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_stable   = stable_q;
    assign out_data    = data_q;
    assign out_changed = chg_q;
    assign out_valid   = valid_q;

endmodule

// File: tb/tb_sw_bank_reader.sv
// tb_sw_bank_reader: directed and random checks of sw_bank_reader against a run-length model.
module tb_sw_bank_reader;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] sw_stable, out_data, out_changed;
    logic         out_valid;

    always #5 clk = ~clk;

    sw_bank_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .sw_stable  (sw_stable),
        .out_data   (out_data),
        .out_changed(out_changed),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a new level is accepted once it has been seen on D+1 consecutive
    // eligible edges (edges outside a pending report) after the two-edge sync delay.
    logic [W-1:0] h1 = '0, h2 = '0, s2m = '0, run_val = '0;
    logic [W-1:0] m_stable = '0, m_data = '0, m_chg = '0;
    logic         m_valid = 1'b0;
    int           run = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h1 = '0; h2 = '0; run = 0; run_val = '0;
            m_stable = '0; m_data = '0; m_chg = '0; m_valid = 1'b0;
        end else begin
            s2m = h2;
            h2 = h1;
            h1 = sw;
            if (m_valid) begin
                if (out_ready) m_valid = 1'b0;
                run = 0;
            end else if (s2m != m_stable) begin
                run = (run > 0 && s2m == run_val) ? run + 1 : 1;
                run_val = s2m;
                if (run == D + 1) begin
                    m_chg = s2m ^ m_stable;
                    m_stable = s2m;
                    m_data = s2m;
                    m_valid = 1'b1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_stable", 32'(sw_stable), 32'(m_stable));
            chk("model_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_data", 32'(out_data), 32'(m_data));
                chk("model_changed", 32'(out_changed), 32'(m_chg));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int lim);
        int k = 0;
        while (!out_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int nv;
        int pos;
        logic [W-1:0] dat;
        @(posedge clk);
        #1 chk_en = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stable", 32'(sw_stable), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
        chk("idle_stable", 32'(sw_stable), 32'd0);

        out_ready = 1'b1;
        sw = 6'b101001;
        cyc(6);
        chk("lat_early", 32'(out_valid), 32'd0);
        cyc(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'b101001);
        chk("lat_changed", 32'(out_changed), 32'b101001);
        chk("lat_stable", 32'(sw_stable), 32'b101001);
        cyc(1);
        chk("lat_one_cycle", 32'(out_valid), 32'd0);

        sw = '0;
        cyc(12);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            sw = (i % 2 == 0) ? 6'b000001 : 6'b000000;
            for (int j = 0; j < 2; j++) begin
                cyc(1);
                nv += int'(out_valid);
            end
        end
        sw = 6'b000001;
        pos = -1;
        dat = '0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (out_valid) begin
                nv++;
                if (pos < 0) pos = i;
                dat = out_data;
            end
        end
        chk("bounce_count", nv, 1);
        chk("bounce_pos", pos, 6);
        chk("bounce_data", 32'(dat), 32'b000001);

        sw = '0;
        cyc(12);
        sw = 6'b000100;
        cyc(2);
        sw = '0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            nv += int'(out_valid);
        end
        chk("glitch_count", nv, 0);
        chk("glitch_stable", 32'(sw_stable), 32'd0);

        sw = 6'b101001;
        cyc(12);
        out_ready = 1'b0;
        sw = 6'b010110;
        wait_valid("bp_wait", 12);
        chk("bp_data", 32'(out_data), 32'b010110);
        chk("bp_changed", 32'(out_changed), 32'b111111);
        cyc(3);
        chk("bp_hold", 32'(out_valid), 32'd1);
        sw = 6'b000011;
        cyc(8);
        chk("bp_hold2", 32'(out_valid), 32'd1);
        chk("bp_hold_data", 32'(out_data), 32'b010110);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("bp_xfer", 32'(out_valid), 32'd0);
        chk("bp_stable", 32'(sw_stable), 32'b010110);
        wait_valid("bp_wait2", 12);
        chk("bp2_data", 32'(out_data), 32'b000011);
        chk("bp2_changed", 32'(out_changed), 32'b010101);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        sw = 6'b110000;
        cyc(4);
        rst_n = 1'b0;
        cyc(1);
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_stable", 32'(sw_stable), 32'd0);
        chk("rs_data", 32'(out_data), 32'd0);
        chk("rs_changed", 32'(out_changed), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        wait_valid("rs_wait", 14);
        chk("rs_rep_data", 32'(out_data), 32'b110000);
        chk("rs_rep_changed", 32'(out_changed), 32'b110000);
        rst_n = 1'b0;
        cyc(2);
        chk("rr_valid", 32'(out_valid), 32'd0);
        chk("rr_stable", 32'(sw_stable), 32'd0);
        rst_n = 1'b1;
        wait_valid("rr_wait", 14);
        chk("rr_rep_data", 32'(out_data), 32'b110000);
        chk("rr_rep_changed", 32'(out_changed), 32'b110000);
        out_ready = 1'b1;
        cyc(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) sw = W'($urandom);
            else if ($urandom_range(0, 30) == 0) sw = sw ^ W'(1 << $urandom_range(0, W - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
